// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Fetch-side lookup is combinational; resolved branches are folded into a
// one-entry pending register and written to the table on the following edge.
// Both lookup and update read the "effective entry" (table entry overridden by
// the pending result on an index match), so back-to-back updates compose.
module btb_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 30,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [PC_W-1:0]  next_pc,
  input  logic             update_valid,
  input  logic [PC_W-1:0]  update_pc,
  input  logic             update_taken,
  input  logic [PC_W-1:0]  update_target,
  input  logic             flush,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [1:0]       ctr;
  } entry_t;

  // Next state of an entry after a resolved branch, given its effective value.
  function automatic entry_t f_update(input entry_t e, input logic [TAG_W-1:0] tag,
                                      input logic taken, input logic [PC_W-1:0] target);
    entry_t r;
    r = e;
    if (e.valid && (e.tag == tag)) begin
      if (taken) begin
        r.target = target;
        r.ctr    = (e.ctr == 2'b11) ? 2'b11 : e.ctr + 2'b01;
      end else begin
        r.ctr    = (e.ctr == 2'b00) ? 2'b00 : e.ctr - 2'b01;
      end
    end else if (taken) begin
      r.valid  = 1'b1;
      r.tag    = tag;
      r.target = target;
      r.ctr    = 2'b10;
    end else begin
      r = e;
    end
    return r;
  endfunction

  // Mispredict: wrong direction, or right "taken" direction to the wrong target.
  function automatic logic f_mispredict(input entry_t e, input logic [TAG_W-1:0] tag,
                                        input logic taken, input logic [PC_W-1:0] target);
    logic pred_t;
    pred_t = e.valid && (e.tag == tag) && e.ctr[1];
    return (pred_t != taken) || (pred_t && taken && (e.target != target));
  endfunction

  entry_t             r_table [ENTRIES];
  logic               r_pend_valid;
  logic [IDX_W-1:0]   r_pend_idx;
  entry_t             r_pend_entry;
  logic [CNT_W-1:0]   r_mis_cnt;

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  entry_t             w_lk_entry;
  entry_t             w_up_entry;
  entry_t             w_up_result;
  logic               w_mispredict;
  logic               w_accept;

  assign w_lk_idx = lookup_pc[IDX_W-1:0];
  assign w_lk_tag = lookup_pc[PC_W-1:IDX_W];
  assign w_up_idx = update_pc[IDX_W-1:0];
  assign w_up_tag = update_pc[PC_W-1:IDX_W];
  assign w_accept = update_valid && !flush;

  // Effective entries for both ports, with the pending write bypassed in.
  always_comb begin
    w_lk_entry = r_table[w_lk_idx];
    w_up_entry = r_table[w_up_idx];
    if (r_pend_valid && (r_pend_idx == w_lk_idx)) begin
      w_lk_entry = r_pend_entry;
    end else begin
      w_lk_entry = r_table[w_lk_idx];
    end
    if (r_pend_valid && (r_pend_idx == w_up_idx)) begin
      w_up_entry = r_pend_entry;
    end else begin
      w_up_entry = r_table[w_up_idx];
    end
  end

  assign w_up_result  = f_update(w_up_entry, w_up_tag, update_taken, update_target);
  assign w_mispredict = f_mispredict(w_up_entry, w_up_tag, update_taken, update_target);

  assign pred_hit         = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
  assign pred_taken       = pred_hit && w_lk_entry.ctr[1];
  assign pred_target      = w_lk_entry.target;
  assign next_pc          = pred_taken ? w_lk_entry.target : lookup_pc + PC_W'(1);
  assign mispredict_count = r_mis_cnt;

  // Table storage: flush clears valid bits and drops the pending write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i].valid <= 1'b0;
      end
    end else if (r_pend_valid) begin
      r_table[r_pend_idx] <= r_pend_entry;
    end
  end

  // Pending register holds the already-computed write result for one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_entry <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_idx   <= w_up_idx;
      r_pend_entry <= w_up_result;
    end else begin
      r_pend_valid <= 1'b0;
    end
  end

  // Saturating mispredict counter; updates dropped by flush are not counted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mis_cnt <= '0;
    end else if (w_accept && w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) begin
      r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters. It is the successor to the fixed 4-entry always-taken predictor.
- Sits in the fetch stage. Fetch PC is looked up combinationally to produce next_pc. Resolved branches from execute update the table through a one-stage registered write path with bypass.
- Adds direction prediction, allocation policy, flush, and a saturating mispredict counter.

Parameters:
ENTRIES, 16, table depth; power of two, >= 2
PC_W, 30, word-address width of PCs and targets
CNT_W, 16, mispredict counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
lookup_pc  in  PC_W  fetch word address
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  pred_hit & counter[1]
pred_target  out  PC_W  stored target of the indexed entry (raw)
next_pc  out  PC_W  pred_taken ? pred_target : lookup_pc+1
update_valid  in  1  resolved branch this cycle
update_pc  in  PC_W  word address of resolved branch
update_taken  in  1  actual direction
update_target  in  PC_W  actual target
flush  in  1  invalidate whole table
mispredict_count  out  CNT_W  saturating count of mispredicted updates

Behaviour:
- IDX_W = log2(ENTRIES). idx = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
- Entry fields: valid, tag, target, ctr[1:0].
- Reset (RST high, async): all valid=0, ctr=2'b01, tag/target=0, pending register cleared, mispredict_count=0.
- Outputs during reset: pred_hit=0, pred_taken=0, next_pc=lookup_pc+1 (mod 2^PC_W).
- Lookup is purely combinational, 0-cycle latency. next_pc wraps modulo 2^PC_W.
- Update pipeline:
  - cycle N: update_valid=1 latches {pc, taken, target} into the pending register.
  - edge ending cycle N+1: the pending update is written to the table.
  - Lookup and update paths read the "effective entry": the table entry, overridden by the pending write result if pending is valid and its idx matches.
  - Back-to-back updates to the same idx therefore compose correctly.
  - Consequence: a lookup in cycle N+1 already sees the update made in cycle N.
- Update rule, evaluated against the effective entry:
  - hit (valid & tag match): ctr+1 if taken, saturating at 3; ctr-1 if not taken, saturating at 0. Target is replaced only when taken.
  - miss & taken: allocate (overwrite). valid=1, tag, target, ctr=2'b10.
  - miss & not taken: no change.
- Mispredict, computed in cycle N from the effective entry for update_pc:
  - predicted direction = hit & ctr[1].
  - mispredict if predicted != update_taken, or (predicted taken & update_taken & target != update_target).
  - mispredict_count increments on the following edge and holds at all-ones.
- Flush:
  - On the edge where flush=1, all valid bits clear; ctr/tag/target are unchanged.
  - Any pending write is dropped.
  - An update_valid in the same cycle is also dropped: it is not latched and not counted.
  - Lookups in a flush cycle still use pre-flush state.
- Reset asserted mid-operation: the pending update is discarded immediately; there is no partial write.

Test Plan:
- Reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, next_pc=0x101, mispredict_count=0.
- update pc=0x105 taken target=0x200 in cycle 0 -> lookup 0x105 in cycle 1 gives hit=1, taken=1, next_pc=0x200; mispredict_count=1 after cycle 1.
- Aliasing, same idx 5, different tag: update 0x115 not taken -> no change, 0x105 still hits. Update 0x115 taken target 0x300 -> 0x105 misses, 0x115 hits.
- Counter saturation on pc 0x105:
  - Three taken updates -> ctr=3.
  - Two not-taken updates -> ctr=1; lookup gives hit=1, taken=0, next_pc=0x106.
  - Third not-taken update -> ctr=0, still valid.
- Back-to-back updates, consecutive cycles, same pc 0x105 at ctr=2: not taken, then not taken -> ctr=0 (not 1), proving the bypass.
- Flush with a coincident update: all lookups miss; count unchanged.
- Counter wrap: CNT_W=2, force 5 mispredicts -> count holds at 3.
